program_loader: RTL

Loads a program image into the 2048 x 16 program memory from a byte stream (UART receiver side) before the CPU starts fetching. It assembles byte pairs into 16-bit instruction words (high byte first), drives a single-cycle write port into program memory at sequential addresses from 0, and stops on a terminator word or when memory is full. While loading it holds `busy` high so the top level can keep the CPU in reset.

---
 rtl/loader_pkg.sv | 19 +
 rtl/byte_pair_assembler.sv | 55 +++++
 rtl/program_loader.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader and the program memory it fills.
//   - LoaderAb / LoaderDb : default program memory address / word widths (2048 x 16)
//   - LoaderEndWord       : default terminator word
//   - loader_state_e      : loader FSM encoding (IDLE=0, WAIT_HI=1, WAIT_LO=2, CHECK=3, DONE=4)
package loader_pkg;

    localparam int unsigned LoaderAb      = 11;
    localparam int unsigned LoaderDb      = 16;
    localparam logic [15:0] LoaderEndWord = 16'h0000;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWaitHi = 3'd1,
        StWaitLo = 3'd2,
        StCheck  = 3'd3,
        StDone   = 3'd4
    } loader_state_e;

endpackage

// File: rtl/byte_pair_assembler.sv
// Byte-pair assembler for the program loader: latches the high byte of each instruction word
// and presents {high, rx_data} as the word being completed by the current low byte.
// Optional macro PROGRAM_LOADER_CHECKSUM_EN adds a running XOR over every accepted byte.
// Ports:
//   clk, reset    : system clock, synchronous active-high reset
//   clear         : restart of a load; clears the high byte (and XOR)
//   hi_en         : rx_data is a high byte, latch it
//   acc_en        : rx_data is an accepted data byte, fold it into the XOR (checksum build only)
//   rx_data       : received byte
//   word          : {latched high byte, rx_data}
//   cksum         : running XOR of accepted bytes (checksum build only)
module byte_pair_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        hi_en,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    input  logic        acc_en,
    output logic [7:0]  cksum,
`endif
    input  logic [7:0]  rx_data,
    output logic [15:0] word
);

    logic [7:0] hi_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= 8'h00;
        end else if (clear) begin
            hi_q <= 8'h00;
        end else if (hi_en) begin
            hi_q <= rx_data;
        end
    end

    assign word = {hi_q, rx_data};

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] xor_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            xor_q <= 8'h00;
        end else if (clear) begin
            xor_q <= 8'h00;
        end else if (acc_en) begin
            xor_q <= xor_q ^ rx_data;
        end
    end

    assign cksum = xor_q;
`endif

endmodule

// File: rtl/program_loader.sv
// Program loader: assembles a received byte stream (high byte first) into instruction words and
// writes them to program memory at sequential addresses from 0. Loading ends on the terminator
// word (which is written) or when the last address has been written (overflow).
// Optional macro PROGRAM_LOADER_CHECKSUM_EN: after the terminator one more byte is compared with
// the XOR of all data bytes; a mismatch raises cksum_err.
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   start               : one-cycle pulse, begins a load from address 0 (IDLE/DONE only)
//   rx_data, rx_valid   : received byte and its one-cycle strobe
//   wr_en/wr_addr/wr_data : registered program memory write port
//   busy                : load in progress (hold CPU in reset)
//   done                : load finished, held until start/reset
//   overflow            : memory filled without a terminator
//   cksum_err           : checksum byte mismatch (checksum build only)
//   word_count          : words written in the current/last load
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned   AB       = LoaderAb,
    parameter int unsigned   DB       = LoaderDb,
    parameter logic [DB-1:0] END_WORD = LoaderEndWord
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          wr_en,
    output logic [AB-1:0] wr_addr,
    output logic [DB-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          overflow,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    output logic          cksum_err,
`endif
    output logic [AB:0]   word_count
);

    localparam logic [AB-1:0] AddrMax = '1;

    loader_state_e state_q, state_d;
    logic [AB-1:0] addr_q, addr_d;
    logic [AB:0]   cnt_q, cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [AB-1:0] wr_addr_q, wr_addr_d;
    logic [DB-1:0] wr_data_q, wr_data_d;
    logic          ovf_q, ovf_d;
    logic          clear, hi_en;
    logic [15:0]   word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic          cerr_q, cerr_d;
    logic          acc_en;
    logic [7:0]    cksum;
`endif

    byte_pair_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .hi_en   (hi_en),
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        .acc_en  (acc_en),
        .cksum   (cksum),
`endif
        .rx_data (rx_data),
        .word    (word)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ovf_d     = ovf_q;
        clear     = 1'b0;
        hi_en     = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        cerr_d    = cerr_q;
        acc_en    = 1'b0;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                // start wins over a coincident byte, which is dropped
                if (start) begin
                    clear   = 1'b1;
                    addr_d  = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    cerr_d  = 1'b0;
`endif
                    state_d = StWaitHi;
                end
            end
            StWaitHi: begin
                if (rx_valid) begin
                    hi_en   = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    acc_en  = 1'b1;
`endif
                    state_d = StWaitLo;
                end
            end
            StWaitLo: begin
                if (rx_valid) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    acc_en    = 1'b1;
`endif
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = word;
                    cnt_d     = cnt_q + (AB+1)'(1);
                    // address counter saturates; the load ends at the last address anyway
                    if (addr_q != AddrMax) begin
                        addr_d = addr_q + (AB)'(1);
                    end
                    if (word == END_WORD) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        state_d = StDone;
`endif
                    end else if (addr_q == AddrMax) begin
                        ovf_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StWaitHi;
                    end
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            StCheck: begin
                if (rx_valid) begin
                    cerr_d  = (rx_data != cksum);
                    state_d = StDone;
                end
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ovf_q     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            cerr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ovf_q     <= ovf_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            cerr_q    <= cerr_d;
`endif
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign word_count = cnt_q;
    assign overflow   = ovf_q;
    assign done       = (state_q == StDone);
    assign busy       = (state_q == StWaitHi) || (state_q == StWaitLo) || (state_q == StCheck);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign cksum_err  = cerr_q;
`endif

endmodule
